// File: rtl/gcd_dispatch.sv
// Job scheduler for the gcd core: buffers tagged operand pairs, issues them
// one at a time, and returns tagged results in order. Zero operands skip the core.
module gcd_dispatch #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     core_start,
    output logic [W-1:0]             core_a,
    output logic [W-1:0]             core_b,
    input  logic [W-1:0]             core_result,
    input  logic                     core_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_gcd,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_bypass,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_CLR,
        WAIT_DONE,
        OUT
    } state_t;

    logic [W-1:0]     mem_a   [DEPTH];
    logic [W-1:0]     mem_b   [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    state_t           state_q;
    logic             core_start_q;
    logic [W-1:0]     core_a_q, core_b_q;
    logic             out_valid_q;
    logic [W-1:0]     out_gcd_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_bypass_q;

    logic [W-1:0]     head_a, head_b;
    logic [TAG_W-1:0] head_tag;

    // Space is judged on the registered count only; a same-cycle pop never frees a slot.
    assign in_ready = !rst && (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == IDLE) && (count_q != '0);

    assign head_a   = mem_a[rd_ptr_q];
    assign head_b   = mem_b[rd_ptr_q];
    assign head_tag = mem_tag[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q]   <= in_a;
            mem_b[wr_ptr_q]   <= in_b;
            mem_tag[wr_ptr_q] <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            core_start_q <= 1'b0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            out_valid_q  <= 1'b0;
            out_gcd_q    <= '0;
            out_tag_q    <= '0;
            out_bypass_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        out_tag_q <= head_tag;
                        // The subtractive core would spin forever on a zero operand.
                        if (head_a == '0 || head_b == '0) begin
                            out_gcd_q    <= head_a | head_b;
                            out_bypass_q <= 1'b1;
                            out_valid_q  <= 1'b1;
                            state_q      <= OUT;
                        end else begin
                            core_a_q     <= head_a;
                            core_b_q     <= head_b;
                            core_start_q <= 1'b1;
                            state_q      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    core_start_q <= 1'b0;
                    state_q      <= WAIT_CLR;
                end
                // core_done may still be high from the previous job here.
                WAIT_CLR: begin
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (core_done) begin
                        out_gcd_q    <= core_result;
                        out_bypass_q <= 1'b0;
                        out_valid_q  <= 1'b1;
                        state_q      <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign core_start = core_start_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign out_valid  = out_valid_q;
    assign out_gcd    = out_gcd_q;
    assign out_tag    = out_tag_q;
    assign out_bypass = out_bypass_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_gcd_dispatch.sv
// Bench for gcd_dispatch: behavioural subtractive core, scoreboard of
// expected tagged results, directed scenarios in one initial block.
module tb_gcd_dispatch;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a, in_b;
    logic [TAG_W-1:0] in_tag;
    logic             core_start;
    logic [W-1:0]     core_a, core_b;
    logic [W-1:0]     core_result;
    logic             core_done;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_gcd;
    logic [TAG_W-1:0] out_tag;
    logic             out_bypass;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    gcd_dispatch #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .core_start(core_start), .core_a(core_a), .core_b(core_b),
        .core_result(core_result), .core_done(core_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_gcd(out_gcd), .out_tag(out_tag), .out_bypass(out_bypass),
        .fifo_count(fifo_count)
    );

    // Subtractive gcd core; done is a level held until the next start.
    logic [W-1:0] cx, cy;
    logic         cbusy;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cx <= '0; cy <= '0; cbusy <= 1'b0;
            core_done <= 1'b0; core_result <= '0;
        end else if (core_start) begin
            cx <= core_a; cy <= core_b; cbusy <= 1'b1; core_done <= 1'b0;
        end else if (cbusy) begin
            if (cx == cy) begin
                core_result <= cx; core_done <= 1'b1; cbusy <= 1'b0;
            end else if (cx > cy)
                cx <= cx - cy;
            else
                cy <= cy - cx;
        end
    end

    typedef struct {
        logic [W-1:0]     g;
        logic [TAG_W-1:0] tag;
        logic             byp;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;
    int n_starts = 0;
    logic [W-1:0] st_a = '0, st_b = '0;

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x = a, y = b, t;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (core_start) begin
            n_starts++; st_a = core_a; st_b = core_b;
        end
        if (!rst && out_valid && out_ready) begin
            chk("out_has_expect", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_gcd", 64'(out_gcd), 64'(e.g));
                chk("out_tag", 64'(out_tag), 64'(e.tag));
                chk("out_bypass", 64'(out_bypass), 64'(e.byp));
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TAG_W-1:0] t);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
        while (!in_ready && n < 500) begin cyc(); n++; end
        chk("push_accept", 64'(in_ready), 64'd1);
        if (in_ready)
            sb.push_back('{gcd_ref(a, b), t, (a == 0 || b == 0)});
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin cyc(); n++; end
        chk("drain_done", 64'(sb.size()), 64'd0);
        cyc(); cyc();
    endtask

    initial begin
        int s0, s1, acc, n;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // core path
        out_ready = 1'b1;
        s0 = n_starts;
        push(48, 18, 3);
        drain(200);
        chk("t1_starts", 64'(n_starts - s0), 64'd1);
        chk("t1_core_a", 64'(st_a), 64'd48);
        chk("t1_core_b", 64'(st_b), 64'd18);

        // bypass path and its two-cycle latency
        s0 = n_starts;
        push(0, 35, 1);
        chk("t2_lat_t1", 64'(out_valid), 64'd0);
        push(0, 0, 2);
        chk("t2_lat_t2", 64'(out_valid), 64'd1);
        chk("t2_lat_gcd", 64'(out_gcd), 64'd35);
        drain(100);
        chk("t2_no_start", 64'(n_starts - s0), 64'd0);

        // backpressure fills the FIFO
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_a = W'((i + 2) * 6); in_b = 9; in_tag = TAG_W'(8 + i);
            if (in_ready) begin
                acc++;
                sb.push_back('{gcd_ref(in_a, in_b), in_tag, 1'b0});
            end
            cyc();
        end
        in_valid = 1'b0;
        chk("t3_accepted", 64'(acc), 64'd5);
        chk("t3_in_ready", 64'(in_ready), 64'd0);
        chk("t3_fifo_count", 64'(fifo_count), 64'd4);
        out_ready = 1'b1;
        drain(1000);

        // output held stable while stalled
        out_ready = 1'b0;
        push(100, 75, 4);
        n = 0;
        while (!out_valid && n < 500) begin cyc(); n++; end
        chk("t4_reach_out", 64'(out_valid), 64'd1);
        s1 = n_starts;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t4_valid", 64'(out_valid), 64'd1);
            chk("t4_gcd", 64'(out_gcd), 64'd25);
            chk("t4_tag", 64'(out_tag), 64'd4);
        end
        chk("t4_no_start", 64'(n_starts - s1), 64'd0);
        out_ready = 1'b1;
        drain(100);

        // mixed back-to-back ordering
        push(1071, 462, 5);
        push(7, 0, 6);
        push(17, 17, 7);
        drain(1000);

        // reset mid-job
        s0 = n_starts;
        push(1000000, 3, 9);
        n = 0;
        while (n_starts == s0 && n < 50) begin cyc(); n++; end
        chk("t6_started", 64'(n_starts - s0), 64'd1);
        repeat (4) cyc();
        sb.delete();
        rst = 1'b1;
        #1;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_core_start", 64'(core_start), 64'd0);
        chk("t6_core_a", 64'(core_a), 64'd0);
        chk("t6_core_b", 64'(core_b), 64'd0);
        chk("t6_out_gcd", 64'(out_gcd), 64'd0);
        chk("t6_out_tag", 64'(out_tag), 64'd0);
        chk("t6_out_bypass", 64'(out_bypass), 64'd0);
        chk("t6_fifo_count", 64'(fifo_count), 64'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        push(12, 8, 10);
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
